// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern engine: pattern modes, sweep directions
// and the prescaler counter width helper.
package led_pattern_pkg;

    localparam logic [1:0] MODE_BINARY  = 2'd0;
    localparam logic [1:0] MODE_SCANNER = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_FILL    = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic int unsigned div_width(input int unsigned div);
        int unsigned w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step prescaler: counts sysclk edges 0..DIV-1 while enabled; tick marks the wrap edge.
module step_prescaler #(
    parameter int unsigned DIV = 8
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);
    import led_pattern_pkg::*;

    localparam int unsigned CNT_W = div_width(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

    assign tick = enable && (div_cnt_q == CNT_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (enable) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: a prescaled step tick advances one of four patterns
// (binary count, scanner, breathing PWM, thermometer fill) onto a registered LED bank.
module led_pattern_gen #(
    parameter int unsigned SYS_CLK_FREQ = 204_000_000,
    parameter int unsigned STEP_FREQ    = 8,
    parameter int unsigned NUM_LEDS     = 8,
    parameter int unsigned PWM_BITS     = 6
) (
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step_tick
);
    import led_pattern_pkg::*;

    localparam int unsigned DIV   = SYS_CLK_FREQ / STEP_FREQ;
    localparam int unsigned POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned LVL_W = $clog2(NUM_LEDS + 1);

    localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(NUM_LEDS - 1);
    localparam logic [LVL_W-1:0]    LVL_LAST  = LVL_W'(NUM_LEDS);
    localparam logic [PWM_BITS-1:0] DUTY_LAST = '1;

    if (DIV < 2 || NUM_LEDS < 1 || PWM_BITS < 2) begin : g_param_check
        $error("led_pattern_gen: need DIV >= 2, NUM_LEDS >= 1, PWM_BITS >= 2");
    end

    logic step;

    step_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .enable(enable),
        .tick  (step)
    );

    logic [1:0]          cur_mode_q, cur_mode_d;
    logic [NUM_LEDS-1:0] step_cnt_q, step_cnt_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                pos_dir_q, pos_dir_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                duty_dir_q, duty_dir_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                level_dir_q, level_dir_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                step_tick_q;

    always_comb begin
        cur_mode_d  = cur_mode_q;
        step_cnt_d  = step_cnt_q;
        pos_d       = pos_q;
        pos_dir_d   = pos_dir_q;
        duty_d      = duty_q;
        duty_dir_d  = duty_dir_q;
        level_d     = level_q;
        level_dir_d = level_dir_q;

        if (step) begin
            if (mode != cur_mode_q) begin
                // Clearing every pattern keeps idle patterns at their initial state,
                // so the next mode entered always starts clean.
                cur_mode_d  = mode;
                step_cnt_d  = '0;
                pos_d       = '0;
                pos_dir_d   = DIR_UP;
                duty_d      = '0;
                duty_dir_d  = DIR_UP;
                level_d     = '0;
                level_dir_d = DIR_UP;
            end else begin
                unique case (cur_mode_q)
                    MODE_BINARY: step_cnt_d = step_cnt_q + 1'b1;
                    MODE_SCANNER: begin
                        if (NUM_LEDS > 1) begin
                            if (pos_dir_q == DIR_UP) begin
                                if (pos_q == POS_LAST) begin
                                    pos_dir_d = DIR_DOWN;
                                    pos_d     = pos_q - 1'b1;
                                end else begin
                                    pos_d = pos_q + 1'b1;
                                end
                            end else if (pos_q == '0) begin
                                pos_dir_d = DIR_UP;
                                pos_d     = pos_q + 1'b1;
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end
                    MODE_BREATHE: begin
                        if (duty_dir_q == DIR_UP) begin
                            if (duty_q == DUTY_LAST) begin
                                duty_dir_d = DIR_DOWN;
                                duty_d     = duty_q - 1'b1;
                            end else begin
                                duty_d = duty_q + 1'b1;
                            end
                        end else if (duty_q == '0) begin
                            duty_dir_d = DIR_UP;
                            duty_d     = duty_q + 1'b1;
                        end else begin
                            duty_d = duty_q - 1'b1;
                        end
                    end
                    MODE_FILL: begin
                        if (level_dir_q == DIR_UP) begin
                            if (level_q == LVL_LAST) begin
                                level_dir_d = DIR_DOWN;
                                level_d     = level_q - 1'b1;
                            end else begin
                                level_d = level_q + 1'b1;
                            end
                        end else if (level_q == '0) begin
                            level_dir_d = DIR_UP;
                            level_d     = level_q + 1'b1;
                        end else begin
                            level_d = level_q - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Breathe compares against the registered duty, so a new duty shows one cycle late.
    always_comb begin
        leds_d = '0;
        unique case (cur_mode_d)
            MODE_BINARY:  leds_d = step_cnt_d;
            MODE_SCANNER: leds_d = NUM_LEDS'(1) << pos_d;
            MODE_BREATHE: leds_d = {NUM_LEDS{pwm_cnt_q < duty_q}};
            MODE_FILL: begin
                for (int i = 0; i < int'(NUM_LEDS); i++) begin
                    leds_d[i] = LVL_W'(i) < level_d;
                end
            end
            default: leds_d = '0;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cur_mode_q  <= MODE_BINARY;
            step_cnt_q  <= '0;
            pos_q       <= '0;
            pos_dir_q   <= DIR_UP;
            duty_q      <= '0;
            duty_dir_q  <= DIR_UP;
            level_q     <= '0;
            level_dir_q <= DIR_UP;
            pwm_cnt_q   <= '0;
            leds_q      <= '0;
            step_tick_q <= 1'b0;
        end else begin
            cur_mode_q  <= cur_mode_d;
            step_cnt_q  <= step_cnt_d;
            pos_q       <= pos_d;
            pos_dir_q   <= pos_dir_d;
            duty_q      <= duty_d;
            duty_dir_q  <= duty_dir_d;
            level_q     <= level_d;
            level_dir_q <= level_dir_d;
            pwm_cnt_q   <= pwm_cnt_q + 1'b1;
            leds_q      <= leds_d;
            step_tick_q <= step;
        end
    end

    assign leds      = leds_q;
    assign step_tick = step_tick_q;

endmodule
